// File: rtl/servo_sched_pkg.sv
// Shared constants and state encoding for the gate servo scheduler.
package servo_sched_pkg;
    localparam int PULSE_W = 12;
    localparam int CNT_W   = 20;

    localparam logic [PULSE_W-1:0] PULSE_OPEN_DEF   = 12'd1000;
    localparam logic [PULSE_W-1:0] PULSE_CLOSED_DEF = 12'd2000;
    localparam logic [CNT_W-1:0]   SETTLE_DEF       = 20'd400_000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_SETTLE,
        S_DONE
    } state_t;
endpackage

// File: rtl/servo_rr_arbiter.sv
// Round-robin pick of the first pending gate at or after rr_ptr.
module servo_rr_arbiter
    import servo_sched_pkg::*;
#(
    parameter int NUM_GATES = 4,
    localparam int GW = $clog2(NUM_GATES)
) (
    input  logic [NUM_GATES-1:0] pending,
    input  logic [GW-1:0]        rr_ptr,
    output logic                 any_pending,
    output logic [GW-1:0]        grant_idx
);
    logic [GW-1:0] idx;

    // Scan farthest-first so the nearest pending gate wins last.
    always_comb begin
        any_pending = |pending;
        grant_idx   = '0;
        idx         = '0;
        for (int i = NUM_GATES - 1; i >= 0; i--) begin
            idx = rr_ptr + GW'(i);
            if (pending[idx]) grant_idx = idx;
        end
    end
endmodule

// File: rtl/servo_gate_scheduler.sv
// Queues per-gate open/close requests and grants one servo move at a time.
module servo_gate_scheduler
    import servo_sched_pkg::*;
#(
    parameter int NUM_GATES = 4,
    parameter logic [PULSE_W-1:0] PULSE_OPEN = PULSE_OPEN_DEF,
    parameter logic [PULSE_W-1:0] PULSE_CLOSED = PULSE_CLOSED_DEF,
    parameter logic [CNT_W-1:0] SETTLE_CYCLES = SETTLE_DEF,
    localparam int GW = $clog2(NUM_GATES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [GW-1:0]                req_gate,
    input  logic                         req_open,
    output logic                         req_ready,
    output logic [PULSE_W*NUM_GATES-1:0] pulse_duration,
    output logic [NUM_GATES-1:0]         gate_is_open,
    output logic                         busy,
    output logic                         done_pulse,
    output logic [GW-1:0]                done_gate
);
    state_t               state;
    state_t               state_nxt;
    logic [NUM_GATES-1:0] pending;
    logic [NUM_GATES-1:0] pending_open;
    logic [GW-1:0]        rr_ptr;
    logic [GW-1:0]        grant_idx;
    logic [GW-1:0]        arb_idx;
    logic                 any_pending;
    logic [CNT_W-1:0]     counter;
    logic                 accept;
    logic                 changed;

    servo_rr_arbiter #(.NUM_GATES(NUM_GATES)) u_arb (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .any_pending (any_pending),
        .grant_idx   (arb_idx)
    );

    assign req_ready = ~pending[req_gate];
    assign accept    = req_valid & req_ready;
    assign busy      = (state != S_IDLE) | (|pending);
    assign changed   = pending_open[grant_idx] != gate_is_open[grant_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (any_pending) state_nxt = S_GRANT;
            S_GRANT:  state_nxt = changed ? S_SETTLE : S_DONE;
            S_SETTLE: if (counter == '0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_duration <= {NUM_GATES{PULSE_CLOSED}};
            gate_is_open   <= '0;
            pending        <= '0;
            pending_open   <= '0;
            rr_ptr         <= '0;
            grant_idx      <= '0;
            counter        <= '0;
            done_pulse     <= 1'b0;
            done_gate      <= '0;
        end else begin
            done_pulse <= 1'b0;
            if (accept) begin
                pending[req_gate]      <= 1'b1;
                pending_open[req_gate] <= req_open;
            end
            unique case (state)
                S_IDLE: begin
                    if (any_pending) grant_idx <= arb_idx;
                end
                S_GRANT: begin
                    pulse_duration[grant_idx*PULSE_W +: PULSE_W] <=
                        pending_open[grant_idx] ? PULSE_OPEN : PULSE_CLOSED;
                    gate_is_open[grant_idx] <= pending_open[grant_idx];
                    pending[grant_idx]      <= 1'b0;
                    rr_ptr                  <= grant_idx + 1'b1;
                    if (changed) counter <= SETTLE_CYCLES - 1'b1;
                end
                S_SETTLE: begin
                    if (counter != '0) counter <= counter - 1'b1;
                end
                S_DONE: begin
                    done_pulse <= 1'b1;
                    done_gate  <= grant_idx;
                end
                default: ;
            endcase
        end
    end
endmodule
